mux_share_arbiter: RTL and testbench
====================================

Name: mux_share_arbiter

Overview:
- Shares one 4-input, WIDTH-bit select datapath among four requesters A, B, C and D.
- Performs round-robin arbitration and drives the select code in the existing encoding.
- Delivers registered data beats to a single consumer with a valid/ready handshake.
- Sits between the four data producers and the downstream consumer; it replaces ad-hoc Select driving.

Parameters:
WIDTH, 4, data width of each requester input and of Out
HOLD_MAX, 4, maximum consecutive accepted beats per grant before forced rotation (legal range 1..15)

Ports:
Clock  input  1  single system clock, rising edge
ResetN  input  1  asynchronous active-low reset
Req  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D
A  input  WIDTH  source 0 data
B  input  WIDTH  source 1 data
C  input  WIDTH  source 2 data
D  input  WIDTH  source 3 data
OutReady  input  1  consumer accepts the beat when OutValid && OutReady at a clock edge
Grant  output  4  one-hot current grant; 0 when idle
Select  output  2  select code of the granted source; A=2'b00, B=2'b10, C=2'b01, D=2'b11, i.e. Select = {idx[0], idx[1]}
Out  output  WIDTH  registered beat data
OutValid  output  1  Out holds an unaccepted beat
Busy  output  1  high in the GRANT state

Behaviour:
- Reset (ResetN low, asynchronous):
  - Grant=0, Select=2'b00, Out=0, OutValid=0, Busy=0.
  - BeatCnt=0, state=IDLE, LastIdx=3, so A has the highest priority after reset.
  - Any in-flight beat is discarded.
- Clock domain: all state updates on the rising edge of Clock; no combinational path from inputs to outputs.
- State IDLE:
  - If Req!=0 at an edge, pick the first set bit searching LastIdx+1, LastIdx+2, ... modulo 4.
  - Load Grant, Select and Out (data of the winner), set OutValid=1 and BeatCnt=0, go to GRANT.
  - Latency: one edge from Req sampled to the first beat valid.
- State GRANT, OutValid=1, OutReady=0: Out, Select and Grant hold stable; source data changes are ignored; BeatCnt is unchanged.
- State GRANT, accept edge (OutValid && OutReady):
  - Continue: if Req[granted] is still high and BeatCnt+1 < HOLD_MAX, reload Out from the granted source, keep OutValid=1 and increment BeatCnt. This gives 1 beat/cycle throughput.
  - Release otherwise: set LastIdx=granted index.
  - After release, if Req != 0, re-arbitrate in the same edge from the new LastIdx. The new grant loads with OutValid=1 and no bubble. The releasing source competes at the lowest priority, so a sole requester is re-granted immediately.
  - After release, if Req == 0: Grant=0, OutValid=0, go to IDLE. Select retains its last value.
- A granted source dropping Req while a beat is pending still has that beat delivered; release happens on that beat's accept.
- OutReady high while OutValid low is ignored.
- BeatCnt width is 4 bits and never wraps, because release occurs at HOLD_MAX.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority A>B>C>D replaces round-robin; LastIdx is unused; HOLD_MAX rotation still forces release, after which the highest-priority requester wins (which may be the same source).
- Undefined: round-robin as above.

Decomposition:
- Shared package mux_share_pkg holds:
  - the Select code constants SEL_A=2'b00, SEL_B=2'b10, SEL_C=2'b01, SEL_D=2'b11;
  - the state encoding IDLE/GRANT;
  - a function idx_to_sel.
- One sub-module is natural: rr_pick4, a combinational pick taking (Req, LastIdx) and returning a one-hot winner and a 2-bit index. Under ARB_FIXED_PRIO_EN it ignores LastIdx.

Test Plan:
- Reset: hold ResetN=0 with Req=4'b1111 -> Grant=0, OutValid=0, Out=0, Select=00. Release reset with Req=0 -> outputs stay idle for 10 cycles.
- Single source: Req=4'b0010, B=4'h9, OutReady=1 -> one edge later Grant=0010, Select=2'b10, Out=9, OutValid=1. Beats continue every cycle with no bubble across the HOLD_MAX boundary.
- Rotation: Req=4'b1111, A..D=1,2,3,4, OutReady=1 -> Out sequence 1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4,1,... with Select sequence 00,10,01,11.
- Backpressure: during a C grant, OutReady=0 for 3 cycles while C changes 5->7 -> Out=5, Select=01, Grant=0100 stable. BeatCnt is unchanged; Out=7 is loaded after the next accept.
- Early drop: C granted, Req[2] falls after its 2nd beat is captured, Req[3]=1 -> after that accept, Grant=1000 and Select=11 on the next cycle with OutValid continuous.
- Async reset mid-grant: assert ResetN low between clock edges while OutValid=1 -> outputs clear immediately. After release with Req=4'b1111, A is granted first.

Source files
------------

// File: rtl/mux_share_pkg.sv
// mux_share_pkg: select codes, FSM state encoding and index-to-select helper for mux_share_arbiter.
package mux_share_pkg;
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b11;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    return idx == 2'd0 ? SEL_A : idx == 2'd1 ? SEL_B : idx == 2'd2 ? SEL_C : SEL_D;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way pick, round-robin after last_idx or fixed A>B>C>D priority
// when ARB_FIXED_PRIO_EN is defined.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last_idx,
  output logic [3:0] win,
  output logic [1:0] idx
);
`ifdef ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^last_idx;
  always_comb begin
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) if (req[k]) idx = 2'(k);
    win = req == 4'b0 ? 4'b0 : 4'b1 << idx;
  end
`else
  // Descending scan so the nearest requester after last_idx overwrites; k=4 wraps to last_idx itself.
  always_comb begin
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) if (req[last_idx + 2'(k)]) idx = last_idx + 2'(k);
    win = req == 4'b0 ? 4'b0 : 4'b1 << idx;
  end
`endif
endmodule

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin share of a 4-input select datapath with registered valid/ready beats;
// ARB_FIXED_PRIO_EN switches the pick to fixed A>B>C>D priority.
module mux_share_arbiter
  import mux_share_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             OutReady,
  output logic [3:0]       Grant,
  output logic [1:0]       Select,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  output logic             Busy
);
  logic [0:0] state;
  logic [1:0] last_idx, cur_idx, pick_idx;
  logic [3:0] beat_cnt, pick_win;
  logic [WIDTH-1:0] src [4];
  logic cont;
  assign src = '{A, B, C, D};
  assign cont = Req[cur_idx] && ({28'd0, beat_cnt} + 32'd1 < 32'(HOLD_MAX));
  assign Busy = state == GRANT;
  // On release the current grant becomes the new last index, so it competes at lowest priority.
  rr_pick4 u_pick (
    .req(Req),
    .last_idx(state == GRANT ? cur_idx : last_idx),
    .win(pick_win),
    .idx(pick_idx)
  );
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      Grant    <= '0;
      Select   <= SEL_A;
      Out      <= '0;
      OutValid <= 1'b0;
      beat_cnt <= '0;
      last_idx <= 2'd3;
      cur_idx  <= 2'd0;
    end else if (state == IDLE ? |Req : OutValid && OutReady) begin
      if (state == GRANT && cont) begin
        Out      <= src[cur_idx];
        beat_cnt <= beat_cnt + 4'd1;
      end else begin
        if (state == GRANT) last_idx <= cur_idx;
        if (|Req) begin
          state    <= GRANT;
          Grant    <= pick_win;
          Select   <= idx_to_sel(pick_idx);
          Out      <= src[pick_idx];
          OutValid <= 1'b1;
          beat_cnt <= '0;
          cur_idx  <= pick_idx;
        end else begin
          state    <= IDLE;
          Grant    <= '0;
          OutValid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: scoreboard bench; expected beats are queued at stimulus time and popped on each accept.
module tb_mux_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] a = '0, b = '0, c = '0, d = '0;
  logic rdy = 1'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [3:0] out;
  logic out_valid, busy;
  int n_chk = 0;
  int n_pass = 0;
  logic [9:0] q [$];
  mux_share_arbiter #(.WIDTH(4), .HOLD_MAX(4)) dut (
    .Clock(clk), .ResetN(rst_n), .Req(req), .A(a), .B(b), .C(c), .D(d),
    .OutReady(rdy), .Grant(grant), .Select(sel), .Out(out), .OutValid(out_valid), .Busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic push(input int idx, input logic [3:0] data);
    logic [1:0] i;
    i = 2'(idx);
    q.push_back({4'b1 << i, i[0], i[1], data});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !out_valid) break;
      cyc();
    end
    chk("drain_q", q.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask
  // Accept happens at the next rising edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n && out_valid && rdy) begin
      if (q.size() == 0) chk("unexpected_beat", {grant, sel, out}, 10'h3ff);
      else begin
        logic [9:0] e;
        e = q.pop_front();
        chk("beat_out", out, e[3:0]);
        chk("beat_sel", sel, e[5:4]);
        chk("beat_grant", grant, e[9:6]);
      end
    end
  end
  initial begin
    cyc();
    cyc();
    chk("rst_grant", grant, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    req = 4'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_valid", out_valid, 0);
      chk("idle_grant", grant, 0);
      chk("idle_busy", busy, 0);
    end
    // single requester B, continuous across HOLD_MAX boundary
    req = 4'b0010;
    b = 4'h9;
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) push(1, 4'h9);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("single_valid", out_valid, 1);
      chk("single_busy", busy, 1);
    end
    req = 4'b0;
    drain();
    // rotation from reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    req = 4'b1111;
    for (int i = 0; i < 20; i++) push((i / 4) % 4, 4'((i / 4) % 4 + 1));
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("rot_valid", out_valid, 1);
    end
    req = 4'b0;
    drain();
    // backpressure on C with D waiting
    req = 4'b1100;
    c = 4'h5;
    d = 4'hd;
    push(2, 4'h5);
    for (int i = 0; i < 3; i++) push(2, 4'h7);
    push(3, 4'hd);
    cyc();
    rdy = 1'b0;
    c = 4'h7;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_out", out, 4'h5);
      chk("bp_sel", sel, 2'b01);
      chk("bp_grant", grant, 4'b0100);
    end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    req = 4'b0;
    drain();
    // early drop of C after its second beat
    req = 4'b1100;
    c = 4'h3;
    d = 4'h8;
    push(2, 4'h3);
    push(2, 4'h3);
    push(3, 4'h8);
    cyc();
    cyc();
    req = 4'b1000;
    cyc();
    chk("drop_grant", grant, 4'b1000);
    chk("drop_sel", sel, 2'b11);
    chk("drop_valid", out_valid, 1);
    req = 4'b0;
    drain();
    // asynchronous reset mid-grant
    req = 4'b1111;
    a = 4'h1;
    cyc();
    chk("pre_arst_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_grant", grant, 0);
    chk("arst_out", out, 0);
    chk("arst_sel", sel, 0);
    q.delete();
    #1 rst_n = 1'b1;
    push(0, 4'h1);
    push(0, 4'h1);
    cyc();
    chk("arst_first_grant", grant, 4'b0001);
    cyc();
    req = 4'b0;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
